// File: rtl/alu_issue_stage.sv
// Issue/writeback sequencer in front of a combinational ALU: IDLE -> EXEC -> WB.
// Optional macro ALU_ISSUE_BYPASS_EN lets a new op be accepted during the writeback handshake.
module alu_issue_stage #(
    parameter int REG_ADDR_W = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_cmd,
    input  logic [7:0]            req_a,
    input  logic [7:0]            req_b,
    input  logic [REG_ADDR_W-1:0] req_dst,
    output logic [2:0]            alu_cmd,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    input  logic [7:0]            alu_rslt,
    input  logic                  alu_flag,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [7:0]            wb_data,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic                  flag_q,
    output logic [CNT_W-1:0]      retired,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] CMD_CMP = 3'b111;

    state_t                r_state;
    logic [2:0]            r_alu_cmd;
    logic [7:0]            r_alu_a;
    logic [7:0]            r_alu_b;
    logic [REG_ADDR_W-1:0] r_dst;
    logic                  r_wb_valid;
    logic [7:0]            r_wb_data;
    logic [REG_ADDR_W-1:0] r_wb_dst;
    logic                  r_flag;
    logic [CNT_W-1:0]      r_retired;
    logic                  w_req_ready;
    logic                  w_accept;

    // Handshake: a transfer happens on any rising edge where valid and ready are both high.
`ifdef ALU_ISSUE_BYPASS_EN
    assign w_req_ready = !reset && ((r_state == IDLE) || ((r_state == WB) && wb_ready));
`else
    assign w_req_ready = !reset && (r_state == IDLE);
`endif
    assign w_accept = req_valid && w_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_alu_cmd  <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_dst      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_dst   <= '0;
            r_flag     <= 1'b0;
            r_retired  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_cmd <= req_cmd;
                        r_alu_a   <= req_a;
                        r_alu_b   <= req_b;
                        r_dst     <= req_dst;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_flag <= alu_flag;
                    if (r_alu_cmd == CMD_CMP) begin
                        r_retired <= r_retired + CNT_W'(1);
                        r_state   <= IDLE;
                    end else begin
                        r_wb_data  <= alu_rslt;
                        r_wb_dst   <= r_dst;
                        r_wb_valid <= 1'b1;
                        r_state    <= WB;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_retired  <= r_retired + CNT_W'(1);
                        // Only reachable with bypass; otherwise w_accept is low in WB.
                        if (w_accept) begin
                            r_alu_cmd <= req_cmd;
                            r_alu_a   <= req_a;
                            r_alu_b   <= req_b;
                            r_dst     <= req_dst;
                            r_state   <= EXEC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign alu_cmd     = r_alu_cmd;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign wb_valid    = r_wb_valid;
    assign wb_data     = r_wb_data;
    assign wb_dst      = r_wb_dst;
    assign flag_q      = r_flag;
    assign retired     = r_retired;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU, writeback scoreboard and latency checks.
module tb_alu_issue_stage;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [2:0]          req_cmd = '0;
    logic [7:0]          req_a = '0;
    logic [7:0]          req_b = '0;
    logic [1:0]          req_dst = '0;
    logic [2:0]          alu_cmd;
    logic [7:0]          alu_a;
    logic [7:0]          alu_b;
    logic [7:0]          alu_rslt;
    logic                alu_flag;
    logic                wb_valid;
    logic                wb_ready = 1'b1;
    logic [7:0]          wb_data;
    logic [1:0]          wb_dst;
    logic                flag_q;
    logic [TB_CNT_W-1:0] retired;
    logic [1:0]          o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ret = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    alu_issue_stage #(.REG_ADDR_W(2), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
        .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
        .alu_rslt(alu_rslt), .alu_flag(alu_flag),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dst(wb_dst),
        .flag_q(flag_q), .retired(retired), .o_dbg_state(o_dbg_state)
    );

    // Stand-in combinational ALU.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'd0;
        alu_flag = 1'b0;
        case (alu_cmd)
            3'b000: begin alu_wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_flag = alu_wide[8]; end
            3'b001: begin alu_wide = {1'b0, alu_a} << alu_b[2:0];  alu_flag = alu_wide[8]; end
            3'b110: begin alu_wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_flag = alu_wide[8]; end
            3'b111: begin alu_wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_flag = (alu_a == alu_b); end
            default: begin alu_wide = {1'b0, alu_a ^ alu_b}; alu_flag = 1'b0; end
        endcase
        alu_rslt = alu_wide[7:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted writeback is compared against the next expected entry.
    always @(negedge clk) begin
        if (!reset && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb", {22'd0, wb_dst, wb_data}, 32'hFFFF_FFFF);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("wb_data", {24'd0, wb_data}, {24'd0, e[7:0]});
                check("wb_dst", {30'd0, wb_dst}, {30'd0, e[9:8]});
            end
        end
    end

    function automatic logic [31:0] ret_exp();
        return exp_ret % (1 << TB_CNT_W);
    endfunction

    // Drive one op to completion; hold = cycles of wb_ready low once in WB.
    task automatic run_op(input logic [2:0] cmd, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] dst, input logic [7:0] exp_data,
                          input logic exp_flag, input int hold);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b; req_dst = dst;
        wb_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (cmd != 3'b111) exp_q.push_back({dst, exp_data});
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("exec_state", {30'd0, o_dbg_state}, 32'd1);
        check("alu_cmd", {29'd0, alu_cmd}, {29'd0, cmd});
        check("alu_a", {24'd0, alu_a}, {24'd0, a});
        check("alu_b", {24'd0, alu_b}, {24'd0, b});
        check("exec_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("exec_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("flag_q", {31'd0, flag_q}, {31'd0, exp_flag});
        if (cmd == 3'b111) begin
            exp_ret++;
            check("cmp_no_wb", {31'd0, wb_valid}, 32'd0);
            check("cmp_idle_ready", {31'd0, req_ready}, 32'd1);
            check("cmp_retired", {28'd0, retired}, ret_exp());
        end else begin
            check("wb_valid_t2", {31'd0, wb_valid}, 32'd1);
            for (int i = 0; i < hold; i++) begin
                check("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
                check("bp_wb_data", {24'd0, wb_data}, {24'd0, exp_data});
                check("bp_wb_dst", {30'd0, wb_dst}, {30'd0, dst});
                check("bp_req_ready", {31'd0, req_ready}, 32'd0);
                check("bp_retired", {28'd0, retired}, ret_exp());
                @(posedge clk); #1;
                if (i == hold - 1) wb_ready = 1'b1;
                @(negedge clk);
            end
            @(posedge clk); #1;
            exp_ret++;
            @(negedge clk);
            check("wb_done_valid", {31'd0, wb_valid}, 32'd0);
            check("wb_done_ready", {31'd0, req_ready}, 32'd1);
            check("wb_retired", {28'd0, retired}, ret_exp());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", {30'd0, o_dbg_state}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_outputs", {alu_cmd, alu_a, alu_b, wb_data, wb_dst}, 32'd0);
        check("rst_flag_retired", {27'd0, flag_q, retired}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        run_op(3'b000, 8'd5,   8'd6, 2'd1, 8'd11,   1'b0, 0);
        run_op(3'b110, 8'd3,   8'd6, 2'd2, 8'hFD,   1'b1, 0);
        run_op(3'b110, 8'd8,   8'd6, 2'd0, 8'd2,    1'b0, 0);
        run_op(3'b111, 8'd4,   8'd4, 2'd1, 8'd0,    1'b1, 0);
        run_op(3'b111, 8'd3,   8'd2, 2'd1, 8'd0,    1'b0, 0);
        run_op(3'b001, 8'h80,  8'd1, 2'd3, 8'h00,   1'b1, 4);

        // Reset while the op sits in EXEC: it must vanish without a writeback.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 3'b000; req_a = 8'd1; req_b = 8'd2; req_dst = 2'd2;
        wb_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rexec_state", {30'd0, o_dbg_state}, 32'd1);
        check("rexec_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ret = 0;
        @(negedge clk);
        check("rexec_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rexec_outputs", {alu_cmd, alu_a, alu_b, wb_data, wb_dst}, 32'd0);
        check("rexec_flag_retired", {27'd0, flag_q, retired}, 32'd0);
        @(negedge clk);
        check("rexec_no_late_wb", {31'd0, wb_valid}, 32'd0);

        run_op(3'b010, 8'hF0, 8'h3C, 2'd1, 8'hCC, 1'b0, 0);
        for (int i = 0; i < 15; i++) begin
            run_op(3'b111, 8'(i), 8'(i), 2'd0, 8'd0, 1'b1, 0);
        end
        check("retired_wrap", {28'd0, retired}, 32'd0);

`ifdef ALU_ISSUE_BYPASS_EN
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 3'b000; req_a = 8'd1; req_b = 8'd1; req_dst = 2'd0;
        wb_ready = 1'b1;
        exp_q.push_back({2'd0, 8'd2});
        @(posedge clk); #1;
        req_a = 8'd2; req_b = 8'd3; req_dst = 2'd1;
        exp_q.push_back({2'd1, 8'd5});
        @(negedge clk);
        check("byp_exec1", {30'd0, o_dbg_state}, 32'd1);
        @(negedge clk);
        check("byp_wb1_valid", {31'd0, wb_valid}, 32'd1);
        check("byp_wb1_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("byp_exec2", {30'd0, o_dbg_state}, 32'd1);
        check("byp_gap", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        check("byp_wb2_valid", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1;
        exp_ret += 2;
        @(negedge clk);
        check("byp_retired", {28'd0, retired}, ret_exp());
`endif

        repeat (2) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
